pulse_generator: RTL and testbench



---
 rtl/pulse_generator_pkg.sv | 30 +++
 rtl/pulse_generator_cycle_counter.sv | 26 ++
 rtl/pulse_generator.sv | 145 ++++++++++++++
 tb/tb_pulse_generator.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pulse_generator_pkg.sv
// Shared types and helpers for pulse_generator.
//   pg_state_t   : phase the next clock edge will produce (delay/high/low/gap)
//   pg_cnt_width : cycle counter width, wide enough for every phase length
//   pg_width_for : bits needed to hold 0..n-1, minimum 1
package pulse_generator_pkg;

  typedef enum logic [1:0] {
    S_DELAY = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_GAP   = 2'd3
  } pg_state_t;

  function automatic int pg_width_for(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // gap is 0 when no burst gap phase exists
  function automatic int pg_cnt_width(input int period, input int start_delay,
                                      input int gap);
    int m;
    m = period;
    if (start_delay + 1 > m) m = start_delay + 1;
    if (gap > m) m = gap;
    return pg_width_for(m);
  endfunction

endpackage

// File: rtl/pulse_generator_cycle_counter.sv
// cycle_counter: generic up-counter with synchronous clear and terminal flag.
//   clk   : clock, rising edge
//   clear : synchronous clear to zero, priority over en
//   en    : count enable
//   last  : terminal count value
//   tc    : high while count == last
module cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] last,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (clear)   count <= '0;
    else if (en) count <= count + WIDTH'(1);
  end

  assign tc = (count == last);

endmodule

// File: rtl/pulse_generator.sv
// pulse_generator: free-running periodic pulse source.
//   clk          : sole clock, rising edge
//   rstn         : synchronous reset, active-high (1 = reset)
//   pulse_o      : registered pulse, HIGH_CYCLES high then PERIOD-HIGH_CYCLES low
//   burst_done_o : (PULSE_GEN_BURST_EN only) one-cycle flag on first gap cycle
// Optional feature macro: PULSE_GEN_BURST_EN adds BURST_LEN/BURST_GAP and
// an idle gap after every BURST_LEN periods.
module pulse_generator
  import pulse_generator_pkg::*;
#(
  parameter int PERIOD      = 10,
  parameter int HIGH_CYCLES = 1,
  parameter int START_DELAY = 0
`ifdef PULSE_GEN_BURST_EN
  ,
  parameter int BURST_LEN   = 4,
  parameter int BURST_GAP   = 20
`endif
) (
  input  logic clk,
  input  logic rstn,
  output logic pulse_o
`ifdef PULSE_GEN_BURST_EN
  ,
  output logic burst_done_o
`endif
);

  if (PERIOD < 2 || PERIOD > 65536) begin : g_bad_period
    $error("pulse_generator: PERIOD out of range 2..65536");
  end
  if (HIGH_CYCLES < 1 || HIGH_CYCLES >= PERIOD) begin : g_bad_high
    $error("pulse_generator: HIGH_CYCLES must be 1..PERIOD-1");
  end
  if (START_DELAY < 0 || START_DELAY > 65535) begin : g_bad_delay
    $error("pulse_generator: START_DELAY out of range 0..65535");
  end

`ifdef PULSE_GEN_BURST_EN
  if (BURST_LEN < 1) begin : g_bad_blen
    $error("pulse_generator: BURST_LEN must be >= 1");
  end
  if (BURST_GAP < 1) begin : g_bad_bgap
    $error("pulse_generator: BURST_GAP must be >= 1");
  end
  localparam int GAP_LEN = BURST_GAP;
`else
  localparam int GAP_LEN = 0;
`endif

  localparam int CW = pg_cnt_width(PERIOD, START_DELAY, GAP_LEN);

  localparam logic [CW-1:0] T_DELAY = (START_DELAY > 0) ? CW'(START_DELAY - 1) : CW'(0);
  localparam logic [CW-1:0] T_HIGH  = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] T_LOW   = CW'(PERIOD - HIGH_CYCLES - 1);
  localparam pg_state_t     S_INIT  = (START_DELAY > 0) ? S_DELAY : S_HIGH;

  // state names the phase the *next* edge emits, so pulse_o is simply
  // (state == S_HIGH) registered; this gives the first high right after E0.
  pg_state_t       state;
  logic [CW-1:0]   last;
  logic            bad_state;
  logic            tc;
  logic            cnt_clear;

  always_comb begin
    last      = '0;
    bad_state = 1'b0;
    case (state)
      S_DELAY: last = T_DELAY;
      S_HIGH:  last = T_HIGH;
      S_LOW:   last = T_LOW;
`ifdef PULSE_GEN_BURST_EN
      S_GAP:   last = CW'(BURST_GAP - 1);
`endif
      default: bad_state = 1'b1;
    endcase
  end

  // every phase ends on its terminal count, so tc doubles as "state changes"
  assign cnt_clear = rstn | tc | bad_state;

  cycle_counter #(.WIDTH(CW)) u_period_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .en    (1'b1),
    .last  (last),
    .tc    (tc)
  );

`ifdef PULSE_GEN_BURST_EN
  localparam int BW = pg_width_for(BURST_LEN);

  logic low_done;
  logic btc;
  logic gap_entry;

  assign low_done = (state == S_LOW) && tc;

  cycle_counter #(.WIDTH(BW)) u_burst_cnt (
    .clk   (clk),
    .clear (rstn | (low_done & btc)),
    .en    (low_done),
    .last  (BW'(BURST_LEN - 1)),
    .tc    (btc)
  );
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= S_INIT;
      pulse_o <= 1'b0;
`ifdef PULSE_GEN_BURST_EN
      gap_entry    <= 1'b0;
      burst_done_o <= 1'b0;
`endif
    end else begin
      pulse_o <= (state == S_HIGH);
`ifdef PULSE_GEN_BURST_EN
      // gap_entry marks the edge entering S_GAP; delaying it once more
      // aligns burst_done_o with the first gap cycle on pulse_o.
      gap_entry    <= low_done && btc;
      burst_done_o <= gap_entry;
`endif
      case (state)
        S_DELAY: if (tc) state <= S_HIGH;
        S_HIGH:  if (tc) state <= S_LOW;
        S_LOW: begin
          if (tc) begin
`ifdef PULSE_GEN_BURST_EN
            state <= btc ? S_GAP : S_HIGH;
`else
            state <= S_HIGH;
`endif
          end
        end
`ifdef PULSE_GEN_BURST_EN
        S_GAP:   if (tc) state <= S_HIGH;
`endif
        default: state <= S_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
module tb_pulse_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b1;
  logic p1, p2, p3;

`ifdef PULSE_GEN_BURST_EN
  logic d1, d2, d3;
  localparam int BL1 = 2, BG1 = 5, BLD = 4, BGD = 20;
`else
  localparam int BL1 = 1, BG1 = 0, BLD = 1, BGD = 0;
`endif

  pulse_generator #(
    .PERIOD(10), .HIGH_CYCLES(1), .START_DELAY(0)
`ifdef PULSE_GEN_BURST_EN
    , .BURST_LEN(2), .BURST_GAP(5)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .pulse_o(p1)
`ifdef PULSE_GEN_BURST_EN
    , .burst_done_o(d1)
`endif
  );

  pulse_generator #(
    .PERIOD(8), .HIGH_CYCLES(3), .START_DELAY(5)
  ) dut_delay (
    .clk(clk), .rstn(rstn), .pulse_o(p2)
`ifdef PULSE_GEN_BURST_EN
    , .burst_done_o(d2)
`endif
  );

  pulse_generator #(
    .PERIOD(2), .HIGH_CYCLES(1), .START_DELAY(0)
  ) dut_fast (
    .clk(clk), .rstn(rstn), .pulse_o(p3)
`ifdef PULSE_GEN_BURST_EN
    , .burst_done_o(d3)
`endif
  );

  typedef struct {
    int   cyc;
    logic p1, p2, p3;
    logic d1, d2, d3;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   k = 0;

  // Expected waveform from k = edges since reset release (k=0 is E0).
  // Returns {burst_done, pulse}.
  function automatic logic [1:0] model(input int kk, input int per, input int hi,
                                       input int dly, input int bl, input int bg);
    int j, cyc;
    logic pl, dn;
    if (kk < dly) return 2'b00;
    j   = kk - dly;
    cyc = bl * per + bg;
    j   = j % cyc;
    pl  = (j < bl * per) && ((j % per) < hi);
    dn  = (bg > 0) && (j == bl * per);
    return {dn, pl};
  endfunction

  task automatic step(input logic r);
    exp_t e;
    logic [1:0] m1, m2, m3;
    @(negedge clk);
    rstn = r;
    m1 = model(k, 10, 1, 0, BL1, BG1);
    m2 = model(k, 8, 3, 5, BLD, BGD);
    m3 = model(k, 2, 1, 0, BLD, BGD);
    e.cyc = r ? -1 : k;
    e.p1 = r ? 1'b0 : m1[0];
    e.p2 = r ? 1'b0 : m2[0];
    e.p3 = r ? 1'b0 : m3[0];
    e.d1 = r ? 1'b0 : m1[1];
    e.d2 = r ? 1'b0 : m2[1];
    e.d3 = r ? 1'b0 : m3[1];
    q.push_back(e);
    if (r) k = 0;
    else   k = k + 1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp, input int cyc);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s k=%0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  // Monitor: output is presented every cycle, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pulse_default", p1, e.p1, e.cyc);
      chk("pulse_delay",   p2, e.p2, e.cyc);
      chk("pulse_period2", p3, e.p3, e.cyc);
`ifdef PULSE_GEN_BURST_EN
      chk("burst_done_default", d1, e.d1, e.cyc);
      chk("burst_done_delay",   d2, e.d2, e.cyc);
      chk("burst_done_period2", d3, e.d3, e.cyc);
`endif
    end
  end

  initial begin
    // reset held for two edges, then 50 default periods
    step(1'b1);
    step(1'b1);
    repeat (500) step(1'b0);

    // restart, then hit reset on the 2nd high cycle of the delayed instance
    step(1'b1);
    repeat (7) step(1'b0);
    step(1'b1);
    step(1'b1);
    repeat (300) step(1'b0);

    @(negedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
